// File: rtl/uart_pkg.sv
// Shared types and elaboration-time helpers for the framed UART transmitter:
// FSM states, parity modes, baud table and divisor arithmetic.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    function automatic int baud_rate(input logic [2:0] sel);
        case (sel)
            3'd0:    return 32'd9600;
            3'd1:    return 32'd19200;
            3'd2:    return 32'd38400;
            3'd3:    return 32'd57600;
            default: return 32'd115200;
        endcase
    endfunction

    // Clock cycles per bit, rounded to the nearest integer.
    function automatic int div_for(input int clk_hz, input logic [2:0] sel);
        int baud;
        baud = baud_rate(sel);
        return (clk_hz + baud / 32'sd2) / baud;
    endfunction

    // The slowest rate has the largest divisor and sets the counter width.
    function automatic int div_width(input int clk_hz);
        int w;
        w = $clog2(div_for(clk_hz, 3'd0));
        return (w < 32'sd1) ? 32'sd1 : w;
    endfunction

    function automatic logic parity_on(input logic [1:0] mode);
        return (mode == PAR_ODD) || (mode == PAR_EVEN);
    endfunction

    // Zero-extended upper bits do not disturb the XOR reduction.
    function automatic logic parity_bit(input logic [8:0] word, input logic [1:0] mode);
        case (mode)
            PAR_ODD:  return ~^word;
            PAR_EVEN: return ^word;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO feeding the transmitter; full/empty are
// registered and a write into a full FIFO is dropped even if a pop coincides.
module uart_tx_fifo #(
    parameter int WIDTH = 32'd8,
    parameter int DEPTH = 32'd4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 32'sd1) ? $clog2(DEPTH) : 32'sd1;
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1'b1);
    localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ZERO  = (AW+1)'(1'b0);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_next_s;
    logic             full_r;
    logic             empty_r;
    logic             wr_ok_s;
    logic             rd_ok_s;

    assign wr_ok_s = wr_en & ~full_r;
    assign rd_ok_s = rd_en & ~empty_r;

    // Occupancy after this cycle's accepted write and pop.
    always_comb begin
        count_next_s = count_r;
        if (wr_ok_s && !rd_ok_s) begin
            count_next_s = count_r + CNT_ONE;
        end else if (!wr_ok_s && rd_ok_s) begin
            count_next_s = count_r - CNT_ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // Pointers, occupancy and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= CNT_ZERO;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ok_s ? wr_ptr_r + PTR_ONE : wr_ptr_r;
            rd_ptr_r <= rd_ok_s ? rd_ptr_r + PTR_ONE : rd_ptr_r;
            count_r  <= count_next_s;
            full_r   <= (count_next_s == CNT_DEPTH);
            empty_r  <= (count_next_s == CNT_ZERO);
        end
    end

    // Storage array; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = full_r;
    assign empty   = empty_r;

endmodule

// File: rtl/uart_frame_tx.sv
// Framed UART transmitter: configurable width, parity and stop bits, fed by
// a small FIFO so queued words leave back-to-back with no idle gap.
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 32'd50_000_000,
    parameter int DATA_BITS   = 32'd8,
    parameter int FIFO_DEPTH  = 32'd4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATA_BITS-1:0] data_byte,
    input  logic                 send_en,
    input  logic [2:0]           baud_set,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
    output logic                 Rs232_Tx,
    output logic                 Tx_Done,
    output logic                 uart_state,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic                 overflow
);

    localparam int DIV_W = div_width(CLK_FREQ_HZ);
    localparam logic [DIV_W-1:0] DIV_LAST_0 = DIV_W'(div_for(CLK_FREQ_HZ, 3'd0) - 32'sd1);
    localparam logic [DIV_W-1:0] DIV_LAST_1 = DIV_W'(div_for(CLK_FREQ_HZ, 3'd1) - 32'sd1);
    localparam logic [DIV_W-1:0] DIV_LAST_2 = DIV_W'(div_for(CLK_FREQ_HZ, 3'd2) - 32'sd1);
    localparam logic [DIV_W-1:0] DIV_LAST_3 = DIV_W'(div_for(CLK_FREQ_HZ, 3'd3) - 32'sd1);
    localparam logic [DIV_W-1:0] DIV_LAST_4 = DIV_W'(div_for(CLK_FREQ_HZ, 3'd4) - 32'sd1);
    localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1'b1);
    localparam logic [3:0]       LAST_DATA  = 4'(DATA_BITS - 32'sd1);

    tx_state_t            state_r, state_next_s;
    logic [DIV_W-1:0]     div_cnt_r, div_cnt_next_s;
    logic [DIV_W-1:0]     div_last_r, div_last_next_s, div_sel_s;
    logic [3:0]           bit_cnt_r, bit_cnt_next_s;
    logic [DATA_BITS-1:0] shift_r, shift_next_s;
    logic [1:0]           par_mode_r, par_mode_next_s;
    logic                 stop2_r, stop2_next_s;
    logic                 par_bit_r, par_bit_next_s;
    logic                 tx_r, tx_next_s;
    logic                 done_r, done_next_s;
    logic                 busy_r, ovf_r;
    logic                 bit_end_s, load_s, pop_s;
    logic [DATA_BITS-1:0] fifo_rd_data_s;
    logic                 fifo_full_s, fifo_empty_s;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (Clk),
        .rst     (Rst),
        .wr_data (data_byte),
        .wr_en   (send_en),
        .rd_en   (pop_s),
        .rd_data (fifo_rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Divisor for the currently requested rate; latched only at frame start.
    always_comb begin
        case (baud_set)
            3'd0:    div_sel_s = DIV_LAST_0;
            3'd1:    div_sel_s = DIV_LAST_1;
            3'd2:    div_sel_s = DIV_LAST_2;
            3'd3:    div_sel_s = DIV_LAST_3;
            default: div_sel_s = DIV_LAST_4;
        endcase
    end

    assign bit_end_s = (div_cnt_r == div_last_r);

    // Next-state, counters, shifter and the registered line value.
    always_comb begin
        state_next_s    = state_r;
        div_cnt_next_s  = div_cnt_r;
        div_last_next_s = div_last_r;
        bit_cnt_next_s  = bit_cnt_r;
        shift_next_s    = shift_r;
        par_mode_next_s = par_mode_r;
        stop2_next_s    = stop2_r;
        par_bit_next_s  = par_bit_r;
        done_next_s     = 1'b0;
        load_s          = 1'b0;
        pop_s           = 1'b0;
        tx_next_s       = 1'b1;

        if (state_r == ST_IDLE) begin
            div_cnt_next_s = {DIV_W{1'b0}};
        end else if (bit_end_s) begin
            div_cnt_next_s = {DIV_W{1'b0}};
        end else begin
            div_cnt_next_s = div_cnt_r + DIV_ONE;
        end

        case (state_r)
            ST_IDLE: begin
                load_s = ~fifo_empty_s;
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_next_s   = ST_DATA;
                    bit_cnt_next_s = 4'd0;
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s && (bit_cnt_r == LAST_DATA)) begin
                    bit_cnt_next_s = 4'd0;
                    state_next_s   = parity_on(par_mode_r) ? ST_PARITY : ST_STOP;
                end else if (bit_end_s) begin
                    bit_cnt_next_s = bit_cnt_r + 4'd1;
                    shift_next_s   = shift_r >> 1;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_next_s   = ST_STOP;
                    bit_cnt_next_s = 4'd0;
                end else begin
                    state_next_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_end_s && (bit_cnt_r == {3'b000, stop2_r})) begin
                    done_next_s  = 1'b1;
                    load_s       = ~fifo_empty_s;
                    state_next_s = ST_IDLE;
                end else if (bit_end_s) begin
                    bit_cnt_next_s = bit_cnt_r + 4'd1;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        // Every frame start (from IDLE or straight out of STOP) pops and latches config.
        if (load_s) begin
            pop_s           = 1'b1;
            state_next_s    = ST_START;
            div_cnt_next_s  = {DIV_W{1'b0}};
            bit_cnt_next_s  = 4'd0;
            shift_next_s    = fifo_rd_data_s;
            div_last_next_s = div_sel_s;
            par_mode_next_s = parity_mode;
            stop2_next_s    = stop2;
            par_bit_next_s  = parity_bit(9'(fifo_rd_data_s), parity_mode);
        end else begin
            pop_s = 1'b0;
        end

        case (state_next_s)
            ST_IDLE:   tx_next_s = 1'b1;
            ST_START:  tx_next_s = 1'b0;
            ST_DATA:   tx_next_s = shift_next_s[0];
            ST_PARITY: tx_next_s = par_bit_next_s;
            ST_STOP:   tx_next_s = 1'b1;
            default:   tx_next_s = 1'b1;
        endcase
    end

    // State and output registers; reset aborts any frame without a done pulse.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r    <= ST_IDLE;
            div_cnt_r  <= {DIV_W{1'b0}};
            div_last_r <= {DIV_W{1'b0}};
            bit_cnt_r  <= 4'd0;
            shift_r    <= {DATA_BITS{1'b0}};
            par_mode_r <= PAR_NONE;
            stop2_r    <= 1'b0;
            par_bit_r  <= 1'b0;
            tx_r       <= 1'b1;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            div_cnt_r  <= div_cnt_next_s;
            div_last_r <= div_last_next_s;
            bit_cnt_r  <= bit_cnt_next_s;
            shift_r    <= shift_next_s;
            par_mode_r <= par_mode_next_s;
            stop2_r    <= stop2_next_s;
            par_bit_r  <= par_bit_next_s;
            tx_r       <= tx_next_s;
            done_r     <= done_next_s;
            busy_r     <= (state_next_s != ST_IDLE);
            ovf_r      <= send_en & fifo_full_s;
        end
    end

    assign Rs232_Tx   = tx_r;
    assign Tx_Done    = done_r;
    assign uart_state = busy_r;
    assign fifo_full  = fifo_full_s;
    assign fifo_empty = fifo_empty_s;
    assign overflow   = ovf_r;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx: table-driven frames plus hand-written
// back-to-back, overflow, mid-frame baud change and mid-frame reset sequences.
module tb_uart_frame_tx;

    logic       clk;
    logic       rst;
    logic [7:0] data_byte;
    logic       send_en;
    logic [2:0] baud_set;
    logic [1:0] parity_mode;
    logic       stop2;
    logic       Rs232_Tx, Tx_Done, uart_state, fifo_full, fifo_empty, overflow;

    uart_frame_tx #(
        .CLK_FREQ_HZ (50_000_000),
        .DATA_BITS   (8),
        .FIFO_DEPTH  (4)
    ) dut (
        .Clk         (clk),
        .Rst         (rst),
        .data_byte   (data_byte),
        .send_en     (send_en),
        .baud_set    (baud_set),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .Rs232_Tx    (Rs232_Tx),
        .Tx_Done     (Tx_Done),
        .uart_state  (uart_state),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic bitq_t [$];
    typedef struct {
        logic [7:0] word;
        logic [1:0] pm;
        logic       s2;
        int         exp_len;
        logic       exp_par;
    } vec_t;

    int   checks;
    int   errors;
    int   div4, div0;
    vec_t vecs [6];
    logic [7:0] ww [6];
    logic exp_full [6];
    logic exp_ovf  [6];
    int    len, perr, ierr;
    logic  par;
    bitq_t bits;

    function automatic int tb_div(input int sel);
        int b;
        case (sel)
            0:       b = 9600;
            1:       b = 19200;
            2:       b = 38400;
            3:       b = 57600;
            default: b = 115200;
        endcase
        return (50_000_000 + b / 2) / b;
    endfunction

    // Expected line levels of one frame, one entry per bit period.
    function automatic bitq_t model_bits(input logic [7:0] w, input logic [1:0] pm, input logic s2);
        bitq_t q;
        int    ones;
        ones = $countones(w);
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(w[i]);
        if (pm == 2'd1) q.push_back((ones % 2) == 0);
        if (pm == 2'd2) q.push_back((ones % 2) == 1);
        q.push_back(1'b1);
        if (s2) q.push_back(1'b1);
        return q;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Follows one frame from cycle c0 until Tx_Done is seen; entered and left on a negedge.
    task automatic run_frame(input logic [7:0] w, input int div, input logic [1:0] pm,
                             input logic s2, input int c0, output int meas, output logic par_s);
        bitq_t fb;
        int    c, lerr, serr, total;
        fb    = model_bits(w, pm, s2);
        total = fb.size() * div;
        c     = c0;
        lerr  = 0;
        serr  = 0;
        par_s = 1'b0;
        while (c < total + 16) begin
            if (c > 0 && Tx_Done === 1'b1) break;
            if (c < total) begin
                if (Rs232_Tx !== fb[c / div]) lerr++;
            end else begin
                lerr++;
            end
            if (uart_state !== 1'b1) serr++;
            if (c == 9 * div + div / 2) par_s = Rs232_Tx;
            c++;
            @(negedge clk);
        end
        meas = c;
        check("frame_line", lerr, 0);
        check("frame_busy", serr, 0);
        check("frame_len", meas, total);
        check("tx_done", Tx_Done, 1);
    endtask

    task automatic do_vec(input vec_t v);
        int   l;
        logic p;
        baud_set    = 3'd4;
        parity_mode = v.pm;
        stop2       = v.s2;
        data_byte   = v.word;
        send_en     = 1'b1;
        @(negedge clk);
        send_en = 1'b0;
        check("lat_line_hi", Rs232_Tx, 1);
        check("lat_not_empty", fifo_empty, 0);
        @(negedge clk);
        check("lat_line_lo", Rs232_Tx, 0);
        check("lat_popped", fifo_empty, 1);
        run_frame(v.word, div4, v.pm, v.s2, 0, l, p);
        check("vec_len", l, v.exp_len);
        if (v.pm == 2'd1 || v.pm == 2'd2) check("vec_parity", p, v.exp_par);
        check("idle_after", uart_state, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        send_en     = 1'b0;
        data_byte   = 8'h00;
        baud_set    = 3'd4;
        parity_mode = 2'd0;
        stop2       = 1'b0;
        div4        = tb_div(4);
        div0        = tb_div(0);

        vecs[0] = '{8'h0C, 2'd0, 1'b0, 4340, 1'b0};
        vecs[1] = '{8'h37, 2'd1, 1'b0, 4774, 1'b0};
        vecs[2] = '{8'h37, 2'd2, 1'b1, 5208, 1'b1};
        for (int i = 3; i < 6; i++) begin
            vecs[i].word    = 8'($urandom);
            vecs[i].pm      = 2'($urandom_range(0, 3));
            vecs[i].s2      = 1'($urandom_range(0, 1));
            vecs[i].exp_len = (10 + ((vecs[i].pm == 2'd1 || vecs[i].pm == 2'd2) ? 1 : 0)
                               + (vecs[i].s2 ? 1 : 0)) * div4;
            vecs[i].exp_par = (vecs[i].pm == 2'd1) ? (($countones(vecs[i].word) % 2) == 0)
                                                   : (($countones(vecs[i].word) % 2) == 1);
        end
        exp_full = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_ovf  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) ww[i] = 8'($urandom);

        repeat (3) @(negedge clk);
        check("rst_tx", Rs232_Tx, 1);
        check("rst_done", Tx_Done, 0);
        check("rst_state", uart_state, 0);
        check("rst_full", fifo_full, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) do_vec(vecs[i]);

        // Two words on consecutive cycles leave back-to-back.
        parity_mode = 2'd0;
        stop2       = 1'b0;
        data_byte   = 8'h37;
        send_en     = 1'b1;
        @(negedge clk);
        data_byte = 8'hA5;
        @(negedge clk);
        send_en = 1'b0;
        check("b2b_queued", fifo_empty, 0);
        run_frame(8'h37, div4, 2'd0, 1'b0, 0, len, par);
        check("b2b_gap", Rs232_Tx, 0);
        check("b2b_pop_empty", fifo_empty, 1);
        run_frame(8'hA5, div4, 2'd0, 1'b0, 0, len, par);
        check("b2b_idle", uart_state, 0);

        // Six-cycle burst into a depth-4 FIFO: one word dropped.
        for (int i = 0; i < 6; i++) begin
            data_byte = ww[i];
            send_en   = 1'b1;
            @(negedge clk);
            check("burst_full", fifo_full, exp_full[i]);
            check("burst_ovf", overflow, exp_ovf[i]);
        end
        send_en = 1'b0;
        @(negedge clk);
        check("ovf_clear", overflow, 0);
        run_frame(ww[0], div4, 2'd0, 1'b0, 5, len, par);
        for (int k = 1; k < 5; k++) begin
            check("burst_gap", Rs232_Tx, 0);
            run_frame(ww[k], div4, 2'd0, 1'b0, 0, len, par);
        end
        check("burst_empty", fifo_empty, 1);
        ierr = 0;
        repeat (2 * div4) begin
            @(negedge clk);
            if (Rs232_Tx !== 1'b1 || uart_state !== 1'b0 || Tx_Done !== 1'b0) ierr++;
        end
        check("no_sixth_frame", ierr, 0);

        // Baud change mid-frame applies to the next frame only.
        data_byte = 8'h5A;
        send_en   = 1'b1;
        @(negedge clk);
        data_byte = 8'h05;
        @(negedge clk);
        send_en = 1'b0;
        fork
            run_frame(8'h5A, div4, 2'd0, 1'b0, 0, len, par);
            begin
                repeat (1500) @(negedge clk);
                baud_set = 3'd0;
            end
        join
        check("slow_gap", Rs232_Tx, 0);
        bits = model_bits(8'h05, 2'd0, 1'b0);
        perr = 0;
        for (int c = 0; c < 2 * div0 + 1000; c++) begin
            if (Rs232_Tx !== bits[c / div0]) perr++;
            if (c > 0 && Tx_Done !== 1'b0) perr++;
            @(negedge clk);
        end
        check("slow_bits", perr, 0);
        check("pre_rst_line", Rs232_Tx, 0);

        // Reset during DATA aborts the frame and flushes the FIFO.
        data_byte = 8'hFF;
        send_en   = 1'b1;
        @(negedge clk);
        send_en = 1'b0;
        check("pre_rst_queued", fifo_empty, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_line", Rs232_Tx, 1);
        check("abort_state", uart_state, 0);
        check("abort_empty", fifo_empty, 1);
        check("abort_done", Tx_Done, 0);
        ierr = 0;
        repeat (2 * div4) begin
            @(negedge clk);
            if (Rs232_Tx !== 1'b1 || uart_state !== 1'b0 || Tx_Done !== 1'b0) ierr++;
        end
        check("abort_quiet", ierr, 0);

        do_vec(vecs[5]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
